// File: rtl/cache_pkg.sv
// Shared definitions for the 4-way set-associative data cache array.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_DATA_W  = 64;
    localparam int unsigned DEF_INDEX_W = 4;
    localparam int unsigned NUM_WAYS    = 4;

    typedef enum logic [1:0] {
        CPU_NONE = 2'b00,
        CPU_LO   = 2'b01,
        CPU_HI   = 2'b10,
        CPU_FULL = 2'b11
    } cpu_mask_e;

    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/cache_4way_if.sv
// Control/data bus between the cache user and cache_4way.
interface cache_4way_if
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic [NUM_WAYS-1:0] write_enable;
    logic [1:0]          write_enable_cpu;
    logic                write_enable_ram;
    logic                read_enable;
    logic [ADDR_W-1:0]   adress;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out1;
    logic [DATA_W-1:0]   data_out2;
    logic [DATA_W-1:0]   data_out3;
    logic [DATA_W-1:0]   data_out4;

    modport master (
        output write_enable, write_enable_cpu, write_enable_ram, read_enable, adress, data_in,
        input  data_out1, data_out2, data_out3, data_out4
    );

    modport slave (
        input  write_enable, write_enable_cpu, write_enable_ram, read_enable, adress, data_in,
        output data_out1, data_out2, data_out3, data_out4
    );
endinterface

// File: rtl/cache_4way_way.sv
// One cache way: valid/tag/data per set, line fill, masked CPU write on hit,
// and a combinational read that yields zero on miss.
module cache_way
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned INDEX_W = DEF_INDEX_W
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel,
    input  logic                      fill,
    input  cpu_mask_e                 cpu_mask,
    input  logic [INDEX_W-1:0]        idx,
    input  logic [ADDR_W-INDEX_W-1:0] tag,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         rd_data
);
    localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);
    localparam int unsigned SETS  = 2 ** INDEX_W;
    localparam int unsigned HALF  = DATA_W / 2;

    logic             valid [SETS];
    logic [TAG_W-1:0] tags  [SETS];
    logic [DATA_W-1:0] data [SETS];
    logic             hit;

    assign hit     = valid[idx] && (tags[idx] == tag);
    assign rd_data = hit ? data[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= 1'b0;
                tags[s]  <= '0;
                data[s]  <= '0;
            end
        end else if (sel) begin
            // A fill wins outright; CPU writes only land on a hit and never touch valid/tag.
            if (fill) begin
                valid[idx] <= 1'b1;
                tags[idx]  <= tag;
                data[idx]  <= data_in;
            end else if (hit) begin
                case (cpu_mask)
                    CPU_LO:   data[idx][HALF-1:0]      <= data_in[HALF-1:0];
                    CPU_HI:   data[idx][DATA_W-1:HALF] <= data_in[DATA_W-1:HALF];
                    CPU_FULL: data[idx]                <= data_in;
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: rtl/cache_4way.sv
// 4-way set-associative data cache array: four ways read in parallel into registered outputs.
module cache_4way
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned INDEX_W = DEF_INDEX_W
)(
    input  logic         clk,
    input  logic         gen_reset,
    cache_4way_if.slave  bus
);
    logic [DATA_W-1:0]         way_rd [NUM_WAYS];
    logic [INDEX_W-1:0]        idx;
    logic [ADDR_W-INDEX_W-1:0] tag;
    cpu_mask_e                 cpu_mask;

    assign idx      = bus.adress[INDEX_W-1:0];
    assign tag      = bus.adress[ADDR_W-1:INDEX_W];
    assign cpu_mask = cpu_mask_e'(bus.write_enable_cpu);

    for (genvar k = 0; k < NUM_WAYS; k++) begin : g_way
        cache_way #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .INDEX_W (INDEX_W)
        ) u_way (
            .clk      (clk),
            .rst      (gen_reset),
            .sel      (bus.write_enable[k]),
            .fill     (bus.write_enable_ram),
            .cpu_mask (cpu_mask),
            .idx      (idx),
            .tag      (tag),
            .data_in  (bus.data_in),
            .rd_data  (way_rd[k])
        );
    end

    // Outputs sample the ways' pre-edge contents, so same-cycle writes are read-first.
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            bus.data_out1 <= '0;
            bus.data_out2 <= '0;
            bus.data_out3 <= '0;
            bus.data_out4 <= '0;
        end else if (bus.read_enable) begin
            bus.data_out1 <= way_rd[0];
            bus.data_out2 <= way_rd[1];
            bus.data_out3 <= way_rd[2];
            bus.data_out4 <= way_rd[3];
        end
    end
endmodule

// File: tb/tb_cache_4way.sv
// Self-checking bench for cache_4way: reference model feeds an expected-output queue.
module tb_cache_4way;
    import cache_pkg::*;

    typedef logic [3:0][63:0] outs_t;

    logic clk = 1'b0;
    logic gen_reset;

    cache_4way_if #(.ADDR_W(10), .DATA_W(64)) bus ();

    cache_4way #(.ADDR_W(10), .DATA_W(64), .INDEX_W(4)) dut (
        .clk       (clk),
        .gen_reset (gen_reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic        m_valid [4][16];
    logic [5:0]  m_tag   [4][16];
    logic [63:0] m_data  [4][16];
    outs_t       m_out;
    outs_t       exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] we, input logic [1:0] cpu,
                              input logic ram, input logic rd, input logic [9:0] a,
                              input logic [63:0] d);
        logic [3:0]  ix;
        logic [5:0]  tg;
        logic [63:0] mask;
        ix   = a[3:0];
        tg   = a[9:4];
        mask = {{32{cpu[1]}}, {32{cpu[0]}}};
        if (r) begin
            for (int k = 0; k < 4; k++)
                for (int s = 0; s < 16; s++) begin
                    m_valid[k][s] = 1'b0;
                    m_tag[k][s]   = 6'd0;
                    m_data[k][s]  = 64'd0;
                end
            m_out = '0;
        end else begin
            if (rd)
                for (int k = 0; k < 4; k++)
                    m_out[k] = (m_valid[k][ix] && m_tag[k][ix] == tg) ? m_data[k][ix] : 64'd0;
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    if (ram) begin
                        m_valid[k][ix] = 1'b1;
                        m_tag[k][ix]   = tg;
                        m_data[k][ix]  = d;
                    end else if (m_valid[k][ix] && m_tag[k][ix] == tg) begin
                        m_data[k][ix] = (m_data[k][ix] & ~mask) | (d & mask);
                    end
                end
            end
        end
        exp_q.push_back(m_out);
    endtask

    task automatic drive(input logic r, input logic [3:0] we, input logic [1:0] cpu,
                         input logic ram, input logic rd, input logic [9:0] a,
                         input logic [63:0] d);
        outs_t e;
        outs_t got;
        gen_reset            = r;
        bus.write_enable     = we;
        bus.write_enable_cpu = cpu;
        bus.write_enable_ram = ram;
        bus.read_enable      = rd;
        bus.adress           = a;
        bus.data_in          = d;
        model_step(r, we, cpu, ram, rd, a, d);
        @(posedge clk);
        #1;
        got = {bus.data_out4, bus.data_out3, bus.data_out2, bus.data_out1};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got %h expected an entry", got);
        end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("sb_out%0d", k + 1), got[k], e[k]);
        end
    endtask

    initial begin
        gen_reset            = 1'b1;
        bus.write_enable     = '0;
        bus.write_enable_cpu = '0;
        bus.write_enable_ram = 1'b0;
        bus.read_enable      = 1'b0;
        bus.adress           = '0;
        bus.data_in          = '0;
        @(negedge clk);

        // 1. reset, then read
        drive(1, 4'b0000, 2'b00, 0, 0, 10'h001, 64'd0);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("reset_out1", bus.data_out1, 64'd0);
        check_eq("reset_out4", bus.data_out4, 64'd0);

        // 2. fill and read
        drive(0, 4'b0001, 2'b00, 1, 0, 10'h001, 64'd15);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("fill_out1", bus.data_out1, 64'd15);
        check_eq("fill_out2", bus.data_out2, 64'd0);

        // 3. masked CPU writes on hit
        drive(0, 4'b0001, 2'b10, 0, 0, 10'h001, 64'hAAAA_BBBB_CCCC_DDDD);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("cpu_hi", bus.data_out1, 64'hAAAA_BBBB_0000_000F);
        drive(0, 4'b0001, 2'b11, 0, 0, 10'h001, 64'hAAAA_BBBB_CCCC_DDDD);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("cpu_full", bus.data_out1, 64'hAAAA_BBBB_CCCC_DDDD);
        drive(0, 4'b0001, 2'b01, 0, 0, 10'h001, 64'h1111_2222_3333_4444);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("cpu_lo", bus.data_out1, 64'hAAAA_BBBB_3333_4444);

        // 4. tag miss: read zero, CPU write dropped
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h011, 64'd0);
        check_eq("miss_read", bus.data_out1, 64'd0);
        drive(0, 4'b0001, 2'b11, 0, 0, 10'h011, 64'hDEAD_BEEF_DEAD_BEEF);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h011, 64'd0);
        check_eq("miss_nowrite", bus.data_out1, 64'd0);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("miss_keep", bus.data_out1, 64'hAAAA_BBBB_3333_4444);

        // 5. multi-way fill with RAM priority over CPU
        drive(0, 4'b1001, 2'b11, 1, 0, 10'h041, 64'd35);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h041, 64'd0);
        check_eq("multi_out1", bus.data_out1, 64'd35);
        check_eq("multi_out2", bus.data_out2, 64'd0);
        check_eq("multi_out3", bus.data_out3, 64'd0);
        check_eq("multi_out4", bus.data_out4, 64'd35);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h001, 64'd0);
        check_eq("multi_evict", bus.data_out1, 64'd0);

        // all-ones address is an ordinary set
        drive(0, 4'b0010, 2'b00, 1, 0, 10'h3FF, 64'd99);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h3FF, 64'd0);
        check_eq("top_addr", bus.data_out2, 64'd99);

        // 6. read-first, then hold, then reset
        drive(0, 4'b0100, 2'b00, 1, 0, 10'h020, 64'h55);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h020, 64'd0);
        check_eq("rf_pre", bus.data_out3, 64'h55);
        drive(0, 4'b0100, 2'b00, 1, 1, 10'h020, 64'd80);
        check_eq("rf_old", bus.data_out3, 64'h55);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h020, 64'd0);
        check_eq("rf_new", bus.data_out3, 64'd80);
        drive(0, 4'b0000, 2'b00, 0, 0, 10'h3FF, 64'd0);
        check_eq("hold", bus.data_out3, 64'd80);
        drive(1, 4'b1111, 2'b11, 1, 1, 10'h020, 64'd7);
        check_eq("rst_out3", bus.data_out3, 64'd0);
        drive(0, 4'b0000, 2'b00, 0, 1, 10'h020, 64'd0);
        check_eq("rst_cleared", bus.data_out3, 64'd0);

        // random traffic against the model, few tags so hits are common
        for (int i = 0; i < 400; i++) begin
            logic [9:0] a;
            a[3:0] = 4'($urandom_range(0, 15));
            a[9:4] = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 2));
            drive(($urandom_range(0, 99) == 0), 4'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom), a, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
